victim_swap_controller: RTL and testbench



---
 rtl/victim_swap_pkg.sv | 17 +
 rtl/victim_swap_controller_if.sv | 47 ++++
 rtl/victim_swap_stats_counter.sv | 26 ++
 rtl/victim_swap_controller.sv | 181 ++++++++++++++++++
 tb/tb_victim_swap_controller.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/victim_swap_pkg.sv
// Shared types and default widths for the victim-cache swap controller.
// FSM encoding, default block/tag widths and statistics counter width.
package victim_swap_pkg;

  localparam int DEF_BLOCK_WIDTH = 512;
  localparam int DEF_TAG_WIDTH   = 26;
  localparam int STATS_WIDTH     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROBE,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_FILL
  } vs_state_e;

endpackage

// File: rtl/victim_swap_controller_if.sv
// Bundle of L1 miss, victim-cache and lower-memory signals for the swap controller.
// master = controller side, slave = environment (L1 / victim cache / memory) side.
interface victim_swap_controller_if
  import victim_swap_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH
);
  logic                   MISS_VALID;
  logic                   MISS_READY;
  logic [TAG_WIDTH-1:0]   MISS_TAG;
  logic                   EVICT_VALID;
  logic [TAG_WIDTH-1:0]   EVICT_TAG;
  logic [BLOCK_WIDTH-1:0] EVICT_DATA;
  logic                   FILL_VALID;
  logic [BLOCK_WIDTH-1:0] FILL_DATA;
  logic                   FILL_FROM_VICTIM;
  logic [TAG_WIDTH-1:0]   VC_WRITE_TAG_ADDRESS;
  logic [BLOCK_WIDTH-1:0] VC_WRITE_DATA;
  logic                   VC_WRITE_ENABLE;
  logic [TAG_WIDTH-1:0]   VC_READ_TAG_ADDRESS;
  logic                   VC_READ_ENBLE;
  logic                   VC_READ_HIT;
  logic [BLOCK_WIDTH-1:0] VC_READ_DATA;
  logic                   MEM_REQ_VALID;
  logic                   MEM_REQ_READY;
  logic [TAG_WIDTH-1:0]   MEM_REQ_TAG;
  logic                   MEM_RESP_VALID;
  logic [BLOCK_WIDTH-1:0] MEM_RESP_DATA;

  modport master (
    input  MISS_VALID, MISS_TAG, EVICT_VALID, EVICT_TAG, EVICT_DATA,
    input  VC_READ_HIT, VC_READ_DATA, MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_DATA,
    output MISS_READY, FILL_VALID, FILL_DATA, FILL_FROM_VICTIM,
    output VC_WRITE_TAG_ADDRESS, VC_WRITE_DATA, VC_WRITE_ENABLE,
    output VC_READ_TAG_ADDRESS, VC_READ_ENBLE, MEM_REQ_VALID, MEM_REQ_TAG
  );

  modport slave (
    output MISS_VALID, MISS_TAG, EVICT_VALID, EVICT_TAG, EVICT_DATA,
    output VC_READ_HIT, VC_READ_DATA, MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_DATA,
    input  MISS_READY, FILL_VALID, FILL_DATA, FILL_FROM_VICTIM,
    input  VC_WRITE_TAG_ADDRESS, VC_WRITE_DATA, VC_WRITE_ENABLE,
    input  VC_READ_TAG_ADDRESS, VC_READ_ENBLE, MEM_REQ_VALID, MEM_REQ_TAG
  );

endinterface

// File: rtl/victim_swap_stats_counter.sv
// Saturating event counter: +1 per cycle with inc_i, holds at all-ones.
// Registered output, synchronous active-high clear.
module victim_swap_stats_counter
  import victim_swap_pkg::*;
#(
  parameter int WIDTH = STATS_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/victim_swap_controller.sv
// L1 miss initiator: probe victim cache, fall back to lower memory, one-cycle fill plus evict write.
// All outputs registered; hit fills at T+LAT+1, memory path holds MEM_REQ until ready. Stats: VICTIM_SWAP_STATS_EN.
module victim_swap_controller
  import victim_swap_pkg::*;
#(
  parameter int BLOCK_WIDTH     = DEF_BLOCK_WIDTH,
  parameter int TAG_WIDTH       = DEF_TAG_WIDTH,
  parameter int VC_READ_LATENCY = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  victim_swap_controller_if.master bus
`ifdef VICTIM_SWAP_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] HIT_COUNT,
  output logic [STATS_WIDTH-1:0] MISS_COUNT
`endif
);

  // Probe latency is limited to 1..4, so a 3-bit down-counter is ample.
  localparam int CNT_W = 3;

  vs_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]   miss_tag_q, miss_tag_d;
  logic                   evict_vld_q, evict_vld_d;
  logic [TAG_WIDTH-1:0]   evict_tag_q, evict_tag_d;
  logic [BLOCK_WIDTH-1:0] evict_data_q, evict_data_d;

  logic                   miss_rdy_q, miss_rdy_d;
  logic                   fill_vld_q, fill_vld_d;
  logic [BLOCK_WIDTH-1:0] fill_data_q, fill_data_d;
  logic                   fill_src_q, fill_src_d;
  logic                   vc_wr_en_q, vc_wr_en_d;
  logic [TAG_WIDTH-1:0]   vc_wr_tag_q, vc_wr_tag_d;
  logic [BLOCK_WIDTH-1:0] vc_wr_data_q, vc_wr_data_d;
  logic                   vc_rd_en_q, vc_rd_en_d;
  logic [TAG_WIDTH-1:0]   vc_rd_tag_q, vc_rd_tag_d;
  logic                   mem_req_vld_q, mem_req_vld_d;
  logic [TAG_WIDTH-1:0]   mem_req_tag_q, mem_req_tag_d;

  logic                   probe_done;
  logic                   evict_write;

  assign probe_done  = (state_q == ST_PROBE) && (cnt_q == '0);
  assign evict_write = evict_vld_q && (evict_tag_q != miss_tag_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_tag_d   = miss_tag_q;
    evict_vld_d  = evict_vld_q;
    evict_tag_d  = evict_tag_q;
    evict_data_d = evict_data_q;
    fill_data_d  = '0;
    fill_src_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.MISS_VALID) begin
          miss_tag_d   = bus.MISS_TAG;
          evict_vld_d  = bus.EVICT_VALID;
          evict_tag_d  = bus.EVICT_TAG;
          evict_data_d = bus.EVICT_DATA;
          cnt_d        = CNT_W'(VC_READ_LATENCY - 1);
          state_d      = ST_PROBE;
        end
      end
      ST_PROBE: begin
        if (cnt_q == '0) begin
          if (bus.VC_READ_HIT) begin
            fill_data_d = bus.VC_READ_DATA;
            fill_src_d  = 1'b1;
            state_d     = ST_FILL;
          end else begin
            state_d = ST_MEM_REQ;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_MEM_REQ: begin
        if (bus.MEM_REQ_READY) begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.MEM_RESP_VALID) begin
          fill_data_d = bus.MEM_RESP_DATA;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered in that state.
    miss_rdy_d    = (state_d == ST_IDLE);
    vc_rd_en_d    = (state_d == ST_PROBE);
    vc_rd_tag_d   = (state_d == ST_PROBE) ? miss_tag_d : '0;
    mem_req_vld_d = (state_d == ST_MEM_REQ);
    mem_req_tag_d = (state_d == ST_MEM_REQ) ? miss_tag_d : '0;
    fill_vld_d    = (state_d == ST_FILL);
    vc_wr_en_d    = (state_d == ST_FILL) && evict_write;
    vc_wr_tag_d   = vc_wr_en_d ? evict_tag_q : '0;
    vc_wr_data_d  = vc_wr_en_d ? evict_data_q : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      miss_tag_q    <= '0;
      evict_vld_q   <= 1'b0;
      evict_tag_q   <= '0;
      evict_data_q  <= '0;
      miss_rdy_q    <= 1'b1;
      fill_vld_q    <= 1'b0;
      fill_data_q   <= '0;
      fill_src_q    <= 1'b0;
      vc_wr_en_q    <= 1'b0;
      vc_wr_tag_q   <= '0;
      vc_wr_data_q  <= '0;
      vc_rd_en_q    <= 1'b0;
      vc_rd_tag_q   <= '0;
      mem_req_vld_q <= 1'b0;
      mem_req_tag_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      miss_tag_q    <= miss_tag_d;
      evict_vld_q   <= evict_vld_d;
      evict_tag_q   <= evict_tag_d;
      evict_data_q  <= evict_data_d;
      miss_rdy_q    <= miss_rdy_d;
      fill_vld_q    <= fill_vld_d;
      fill_data_q   <= fill_data_d;
      fill_src_q    <= fill_src_d;
      vc_wr_en_q    <= vc_wr_en_d;
      vc_wr_tag_q   <= vc_wr_tag_d;
      vc_wr_data_q  <= vc_wr_data_d;
      vc_rd_en_q    <= vc_rd_en_d;
      vc_rd_tag_q   <= vc_rd_tag_d;
      mem_req_vld_q <= mem_req_vld_d;
      mem_req_tag_q <= mem_req_tag_d;
    end
  end

  assign bus.MISS_READY           = miss_rdy_q;
  assign bus.FILL_VALID           = fill_vld_q;
  assign bus.FILL_DATA            = fill_data_q;
  assign bus.FILL_FROM_VICTIM     = fill_src_q;
  assign bus.VC_WRITE_ENABLE      = vc_wr_en_q;
  assign bus.VC_WRITE_TAG_ADDRESS = vc_wr_tag_q;
  assign bus.VC_WRITE_DATA        = vc_wr_data_q;
  assign bus.VC_READ_ENBLE        = vc_rd_en_q;
  assign bus.VC_READ_TAG_ADDRESS  = vc_rd_tag_q;
  assign bus.MEM_REQ_VALID        = mem_req_vld_q;
  assign bus.MEM_REQ_TAG          = mem_req_tag_q;

`ifdef VICTIM_SWAP_STATS_EN
  victim_swap_stats_counter #(.WIDTH(STATS_WIDTH)) u_hit_cnt (
    .clk_i   (CLK),
    .rst_i   (RST),
    .inc_i   (probe_done && bus.VC_READ_HIT),
    .count_o (HIT_COUNT)
  );

  victim_swap_stats_counter #(.WIDTH(STATS_WIDTH)) u_miss_cnt (
    .clk_i   (CLK),
    .rst_i   (RST),
    .inc_i   (probe_done && !bus.VC_READ_HIT),
    .count_o (MISS_COUNT)
  );
`endif

endmodule

// File: tb/tb_victim_swap_controller.sv
// Bench for victim_swap_controller: fixed vectors, hand-written reset sequences and random transactions
// compared cycle by cycle against a per-transaction timeline model.
module tb_victim_swap_controller;
  import victim_swap_pkg::*;

  localparam int BW  = 512;
  localparam int TW  = 26;
  localparam int LAT = 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  victim_swap_controller_if #(.BLOCK_WIDTH(BW), .TAG_WIDTH(TW)) bus ();

`ifdef VICTIM_SWAP_STATS_EN
  logic [STATS_WIDTH-1:0] HIT_COUNT, MISS_COUNT;
`endif

  victim_swap_controller #(.BLOCK_WIDTH(BW), .TAG_WIDTH(TW), .VC_READ_LATENCY(LAT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef VICTIM_SWAP_STATS_EN
    ,
    .HIT_COUNT  (HIT_COUNT),
    .MISS_COUNT (MISS_COUNT)
`endif
  );

  typedef struct packed {
    logic          miss_rdy;
    logic          fill_vld;
    logic          fill_src;
    logic          vc_wr_en;
    logic          vc_rd_en;
    logic          mem_req_vld;
    logic [TW-1:0] vc_wr_tag;
    logic [TW-1:0] vc_rd_tag;
    logic [TW-1:0] mem_tag;
    logic [BW-1:0] fill_data;
    logic [BW-1:0] vc_wr_data;
  } exp_t;

  typedef struct {
    logic          hit;
    logic          evict_vld;
    logic [TW-1:0] mtag;
    logic [TW-1:0] etag;
    logic [BW-1:0] edata;
    logic [BW-1:0] vdata;
    logic [BW-1:0] mdata;
    int            d_rdy;
    int            d_resp;
    logic          exp_src;
    logic          exp_wr;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int model_hits = 0;
  int model_misses = 0;

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [TW-1:0] rand_tag();
    return TW'($urandom);
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.miss_rdy = 1'b1;
    return e;
  endfunction

  function automatic int fill_cycle(vec_t v);
    return v.hit ? LAT + 1 : LAT + 3 + v.d_rdy + v.d_resp;
  endfunction

  // Expected outputs r cycles after the miss was offered (r=0 is the offer cycle).
  function automatic exp_t expect_at(int r, vec_t v);
    exp_t e;
    int   f;
    e = '0;
    f = fill_cycle(v);
    if (r == 0 || r > f) begin
      e.miss_rdy = 1'b1;
    end else if (r <= LAT) begin
      e.vc_rd_en  = 1'b1;
      e.vc_rd_tag = v.mtag;
    end else if (r == f) begin
      e.fill_vld  = 1'b1;
      e.fill_src  = v.exp_src;
      e.fill_data = v.exp_src ? v.vdata : v.mdata;
      if (v.exp_wr) begin
        e.vc_wr_en   = 1'b1;
        e.vc_wr_tag  = v.etag;
        e.vc_wr_data = v.edata;
      end
    end else if (r <= LAT + 1 + v.d_rdy) begin
      e.mem_req_vld = 1'b1;
      e.mem_tag     = v.mtag;
    end
    return e;
  endfunction

  task automatic check(input string name, input int cyc, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s r=%0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic compare(input string name, input int r, input exp_t e);
    check({name, ".ctrl"}, r,
          BW'({bus.MISS_READY, bus.FILL_VALID, bus.FILL_FROM_VICTIM,
               bus.VC_WRITE_ENABLE, bus.VC_READ_ENBLE, bus.MEM_REQ_VALID}),
          BW'({e.miss_rdy, e.fill_vld, e.fill_src, e.vc_wr_en, e.vc_rd_en, e.mem_req_vld}));
    check({name, ".tags"}, r,
          BW'({bus.VC_WRITE_TAG_ADDRESS, bus.VC_READ_TAG_ADDRESS, bus.MEM_REQ_TAG}),
          BW'({e.vc_wr_tag, e.vc_rd_tag, e.mem_tag}));
    check({name, ".fill_data"}, r, bus.FILL_DATA, e.fill_data);
    check({name, ".vc_wr_data"}, r, bus.VC_WRITE_DATA, e.vc_wr_data);
  endtask

  // Inputs the controller must ignore get random values; only the sampled cycles carry the scenario.
  task automatic drive(input int r, input vec_t v);
    int accept;
    int resp;
    accept = LAT + 1 + v.d_rdy;
    resp   = accept + 1 + v.d_resp;
    bus.MISS_VALID     = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    bus.MISS_TAG       = (r == 0) ? v.mtag : rand_tag();
    bus.EVICT_VALID    = (r == 0) ? v.evict_vld : 1'($urandom_range(0, 1));
    bus.EVICT_TAG      = (r == 0) ? v.etag : rand_tag();
    bus.EVICT_DATA     = (r == 0) ? v.edata : rand_blk();
    bus.VC_READ_HIT    = (r == LAT) ? v.hit : 1'($urandom_range(0, 1));
    bus.VC_READ_DATA   = (r == LAT) ? v.vdata : rand_blk();
    bus.MEM_REQ_READY  = 1'($urandom_range(0, 1));
    bus.MEM_RESP_VALID = 1'($urandom_range(0, 1));
    bus.MEM_RESP_DATA  = rand_blk();
    if (!v.hit) begin
      if (r > LAT && r < accept) bus.MEM_REQ_READY = 1'b0;
      if (r == accept) bus.MEM_REQ_READY = 1'b1;
      if (r > accept && r < resp) bus.MEM_RESP_VALID = 1'b0;
      if (r == resp) begin
        bus.MEM_RESP_VALID = 1'b1;
        bus.MEM_RESP_DATA  = v.mdata;
      end
    end
  endtask

  task automatic drive_idle();
    bus.MISS_VALID     = 1'b0;
    bus.MISS_TAG       = rand_tag();
    bus.EVICT_VALID    = 1'($urandom_range(0, 1));
    bus.EVICT_TAG      = rand_tag();
    bus.EVICT_DATA     = rand_blk();
    bus.VC_READ_HIT    = 1'($urandom_range(0, 1));
    bus.VC_READ_DATA   = rand_blk();
    bus.MEM_REQ_READY  = 1'($urandom_range(0, 1));
    bus.MEM_RESP_VALID = 1'($urandom_range(0, 1));
    bus.MEM_RESP_DATA  = rand_blk();
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      compare(name, i, idle_exp());
      drive_idle();
    end
  endtask

  task automatic run_txn(input string name, input vec_t v);
    for (int r = 0; r <= fill_cycle(v); r++) begin
      @(negedge CLK);
      compare(name, r, expect_at(r, v));
      drive(r, v);
    end
    if (v.hit) model_hits++;
    else model_misses++;
  endtask

  vec_t tbl[7];
  vec_t v;

  initial begin
    tbl[0] = '{hit: 1'b1, evict_vld: 1'b1, mtag: 26'h1, etag: 26'h2, edata: 512'hAB, vdata: 512'h1,
               mdata: 512'h0, d_rdy: 0, d_resp: 0, exp_src: 1'b1, exp_wr: 1'b1};
    tbl[1] = '{hit: 1'b0, evict_vld: 1'b1, mtag: 26'h1, etag: 26'h2, edata: 512'hCD, vdata: 512'h9,
               mdata: 512'h5, d_rdy: 3, d_resp: 2, exp_src: 1'b0, exp_wr: 1'b1};
    tbl[2] = '{hit: 1'b0, evict_vld: 1'b0, mtag: 26'h3, etag: 26'h4, edata: 512'hEE, vdata: 512'h0,
               mdata: 512'h77, d_rdy: 0, d_resp: 0, exp_src: 1'b0, exp_wr: 1'b0};
    tbl[3] = '{hit: 1'b1, evict_vld: 1'b1, mtag: 26'h7, etag: 26'h7, edata: 512'h11, vdata: 512'h42,
               mdata: 512'h0, d_rdy: 0, d_resp: 0, exp_src: 1'b1, exp_wr: 1'b0};
    tbl[4] = '{hit: 1'b0, evict_vld: 1'b1, mtag: 26'h7, etag: 26'h7, edata: 512'h22, vdata: 512'h0,
               mdata: 512'h99, d_rdy: 1, d_resp: 0, exp_src: 1'b0, exp_wr: 1'b0};
    tbl[5] = '{hit: 1'b1, evict_vld: 1'b0, mtag: 26'h10, etag: 26'h20, edata: 512'h33, vdata: 512'h55,
               mdata: 512'h0, d_rdy: 0, d_resp: 0, exp_src: 1'b1, exp_wr: 1'b0};
    tbl[6] = '{hit: 1'b1, evict_vld: 1'b1, mtag: 26'h3FFFFFF, etag: 26'h3FFFFFE, edata: {16{32'hDEADBEEF}},
               vdata: {512{1'b1}}, mdata: 512'h0, d_rdy: 0, d_resp: 0, exp_src: 1'b1, exp_wr: 1'b1};

    // Reset held for two cycles with noisy inputs.
    RST = 1'b1;
    drive_idle();
    @(negedge CLK);
    drive_idle();
    @(negedge CLK);
    compare("reset_hold", 0, idle_exp());
    RST = 1'b0;
    drive_idle();
    idle_cycles("reset_release", 1);

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i]);
    end
    idle_cycles("post_vec", 2);

    // Reset while waiting for memory, then a late response that must be dropped.
    v = '{hit: 1'b0, evict_vld: 1'b1, mtag: 26'h5A, etag: 26'h5B, edata: 512'h66, vdata: 512'h0,
          mdata: 512'h88, d_rdy: 0, d_resp: 3, exp_src: 1'b0, exp_wr: 1'b1};
    for (int r = 0; r <= LAT + 2; r++) begin
      @(negedge CLK);
      compare("rst_mid_pre", r, expect_at(r, v));
      drive(r, v);
    end
    RST = 1'b1;
    bus.MEM_RESP_VALID = 1'b0;
    @(negedge CLK);
    compare("rst_mid_reset", 0, idle_exp());
    RST = 1'b0;
    drive_idle();
    bus.MEM_RESP_VALID = 1'b1;
    bus.MEM_RESP_DATA  = v.mdata;
    model_hits   = 0;
    model_misses = 0;
    idle_cycles("rst_mid_after", 4);

    for (int i = 0; i < 40; i++) begin
      v.hit       = 1'($urandom_range(0, 1));
      v.evict_vld = 1'($urandom_range(0, 3) != 0);
      v.mtag      = rand_tag();
      v.etag      = ($urandom_range(0, 3) == 0) ? v.mtag : rand_tag();
      v.edata     = rand_blk();
      v.vdata     = rand_blk();
      v.mdata     = rand_blk();
      v.d_rdy     = $urandom_range(0, 3);
      v.d_resp    = $urandom_range(0, 3);
      v.exp_src   = v.hit;
      v.exp_wr    = v.evict_vld && (v.etag != v.mtag);
      run_txn($sformatf("rnd%0d", i), v);
      if ($urandom_range(0, 1) == 1) idle_cycles("rnd_gap", $urandom_range(1, 2));
    end
    idle_cycles("final_idle", 2);

`ifdef VICTIM_SWAP_STATS_EN
    check("hit_count", 0, BW'(HIT_COUNT), BW'(model_hits));
    check("miss_count", 0, BW'(MISS_COUNT), BW'(model_misses));
    force dut.u_hit_cnt.cnt_q = 32'hFFFFFFFE;
    @(negedge CLK);
    release dut.u_hit_cnt.cnt_q;
    drive_idle();
    run_txn("sat0", tbl[0]);
    run_txn("sat1", tbl[5]);
    idle_cycles("sat_idle", 1);
    check("hit_count_sat", 0, BW'(HIT_COUNT), BW'(32'hFFFFFFFF));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
